// File: rtl/sort4_scheduler.sv
// Block sorter: loads DEPTH words serially, bubble-sorts them in place with one
// shared compare-and-swap (larger first), then streams the block out.
module sort4_scheduler #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [7:0]       swap_count
);
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_J   = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [IW-1:0]    j_q, j_d;
    logic [IW-1:0]    pass_q, pass_d;
    logic [7:0]       swap_count_q, swap_count_d;
    logic [IW-1:0]    j_nxt;
    logic [WIDTH-1:0] cmp_lo, cmp_hi;

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        j_d          = j_q;
        pass_d       = pass_q;
        swap_count_d = swap_count_q;
        j_nxt        = j_q + IW'(1);
        cmp_lo       = mem_q[j_q];
        cmp_hi       = mem_q[j_nxt];

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d     = '0;
                        j_d          = '0;
                        pass_d       = '0;
                        swap_count_d = 8'd0;
                        state_d      = ST_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            ST_SORT: begin
                // Strict compare keeps equal words in place.
                if (cmp_hi > cmp_lo) begin
                    mem_d[j_q]   = cmp_hi;
                    mem_d[j_nxt] = cmp_lo;
                    swap_count_d = swap_count_q + 8'd1;
                end
                if (j_q == LAST_J) begin
                    j_d = '0;
                    if (pass_q == LAST_J) begin
                        pass_d   = '0;
                        rd_idx_d = '0;
                        state_d  = ST_OUT;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            j_q          <= '0;
            pass_q       <= '0;
            swap_count_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            j_q          <= j_d;
            pass_q       <= pass_d;
            swap_count_q <= swap_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs depend only on state, buffer and reset, never on in_valid/out_ready.
    assign in_ready   = rst_n && (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_OUT);
    assign out_data   = out_valid ? mem_q[rd_idx_q] : '0;
    assign busy       = (state_q == ST_SORT);
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort4_scheduler.sv
// Directed + randomized bench for sort4_scheduler; reference model sorts each
// block by repeated max-selection and counts swaps as the block's inversions.
module tb_sort4_scheduler;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [7:0]       swap_count;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] cur_blk [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    int               exp_swaps;

    sort4_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .swap_count(swap_count)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_blk(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        cur_blk[0] = a;
        cur_blk[1] = b;
        cur_blk[2] = c;
        cur_blk[3] = d;
    endtask

    // Reference model: descending order by max-selection, swaps = inversions.
    task automatic build_expected();
        logic [WIDTH-1:0] work [$];
        int best;
        exp_q.delete();
        exp_swaps = 0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = i + 1; j < DEPTH; j++) begin
                if (cur_blk[j] > cur_blk[i]) exp_swaps++;
            end
            work.push_back(cur_blk[i]);
        end
        while (work.size() > 0) begin
            best = 0;
            for (int k = 1; k < work.size(); k++) begin
                if (work[k] > work[best]) best = k;
            end
            exp_q.push_back(work[best]);
            work.delete(best);
        end
    endtask

    // Driver tasks: each starts and ends at a falling edge.
    task automatic load_block(input int gap_before);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == gap_before) begin
                for (int g = 0; g < 2; g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom_range(0, 255));
                    @(negedge clk);
                    check("in_ready_gap", 32'(in_ready), 32'd1);
                end
            end
            in_valid = 1'b1;
            in_data  = cur_blk[i];
            check("in_ready_load", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sort();
        int n;
        n = 0;
        check("in_ready_sort", 32'(in_ready), 32'd0);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd9);
        check("out_valid_rise", 32'(out_valid), 32'd1);
    endtask

    task automatic read_block(input int stall_at);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(exp_q[i]));
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", 32'(out_data), 32'(exp_q[i]));
            if (i == 0) check("swap_count_out", 32'(swap_count), 32'(exp_swaps));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_out_data", 32'(out_data), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("swap_count_hold", 32'(swap_count), 32'(exp_swaps));
    endtask

    task automatic run_block(input int gap_before, input int stall_at, input bit junk);
        build_expected();
        load_block(gap_before);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
        end
        wait_sort();
        in_valid = 1'b0;
        read_block(stall_at);
    endtask

    initial begin
        int g, s;
        // Reset block
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_swap_count", 32'(swap_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_out_valid", 32'(out_valid), 32'd0);

        // Directed blocks, back-to-back with no idle cycles between them
        set_blk(8'h1C, 8'hFA, 8'hFC, 8'h1C);
        run_block(-1, -1, 1'b0);
        check("dup_swaps", 32'(exp_swaps), 32'd3);
        set_blk(8'h00, 8'h01, 8'h02, 8'h03);
        run_block(2, -1, 1'b1);
        set_blk(8'hFF, 8'h80, 8'h01, 8'h00);
        run_block(-1, 1, 1'b0);
        set_blk(8'h00, 8'h00, 8'h00, 8'h00);
        run_block(-1, -1, 1'b0);

        // Reset in the fourth SORT cycle
        set_blk(8'h01, 8'h02, 8'h03, 8'h04);
        load_block(-1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_swap_count", 32'(swap_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
        check("midrst_rel_busy", 32'(busy), 32'd0);
        set_blk(8'h05, 8'h09, 8'h01, 8'h07);
        run_block(-1, -1, 1'b0);

        // Randomized blocks with random load gaps and output stalls
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r % 3 == 0) cur_blk[i] = 8'($urandom_range(0, 3));
                else            cur_blk[i] = 8'($urandom_range(0, 255));
            end
            g = $urandom_range(0, DEPTH);
            if (g == DEPTH) g = -1;
            s = $urandom_range(0, DEPTH);
            if (s == DEPTH) s = -1;
            run_block(g, s, 1'($urandom_range(0, 1)));
        end

        // Final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sort4_scheduler.md
# sort4_scheduler

Sequential sorting controller that reuses a single unsigned compare-and-swap element (larger value first) to sort a block of DEPTH words into descending order. Words are loaded serially through a valid/ready input port and sorted in place by a fixed-schedule bubble pass sequencer. The sorted block is then streamed out through a valid/ready output port. It sits between a serial producer and consumer and time-shares one comparator instead of instantiating a full sorting network.

## Interface
- WIDTH, 8: data word width in bits, unsigned.
- DEPTH, 4: words per block; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  WIDTH  input word.
- in_ready  out  1  block accepts a word this cycle.
- out_valid  out  1  out_data holds a sorted word.
- out_data  out  WIDTH  sorted word, largest first.
- out_ready  in  1  consumer accepts out_data this cycle.
- busy  out  1  high while in SORT.
- swap_count  out  8  number of swaps performed in the most recent sort.

## Operation
- Three states: LOAD, SORT, OUT. Reset enters LOAD, clears buffer, indices, and swap_count to 0.
- LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - When in_valid&&in_ready, store in_data at buf[wr_idx] and increment wr_idx.
  - When the DEPTH-th word is accepted, go to SORT and reset wr_idx to 0.
  - in_valid low stalls loading with no side effects.
- SORT:
  - in_ready=0, busy=1, in_valid ignored.
  - On entry, swap_count clears to 0. Then one compare per cycle on the pair (buf[j], buf[j+1]).
  - If buf[j+1] > buf[j] (unsigned), swap the pair and increment swap_count. Equal values are never swapped.
  - j runs 0..DEPTH-2 within a pass, and a fixed DEPTH-1 passes are executed. There is no early exit.
  - After the last compare, go to OUT with rd_idx=0.
- OUT:
  - out_valid=1, out_data=buf[rd_idx], busy=0, in_ready=0.
  - When out_valid&&out_ready, increment rd_idx.
  - After the DEPTH-th transfer, go to LOAD with out_valid=0 the next cycle.
  - out_ready low holds out_data and out_valid stable.
- When out_valid=0, out_data=0.
- swap_count holds its value through OUT and the following LOAD, until the next SORT entry.
- Reset asserted in any state, including mid-SORT or mid-OUT: all outputs go to 0 immediately and the partial block is discarded. After release, the block is in LOAD with in_ready=1.

## Timing
- Edge numbering: the last input word is accepted on edge k.
- Edge k+1 starts SORT, and busy=1 in the cycle after edge k.
- SORT lasts exactly (DEPTH-1)^2 cycles (9 for DEPTH=4).
- out_valid rises in the cycle after edge k+(DEPTH-1)^2.
- Minimum block period with in_valid and out_ready held high: DEPTH + (DEPTH-1)^2 + DEPTH cycles (17 for DEPTH=4).
- All outputs are registered or derived from state and buffer only. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Reset values: in_ready=1 after release (0 while rst_n=0), out_valid=0, out_data=0, busy=0, swap_count=0.

## Test plan
- Reset check:
  - While rst_n=0: all outputs are 0.
  - After release: in_ready=1 and state is LOAD.
- Mixed block with a duplicate (also checks sort latency):
  - Load 0x1C, 0xFA, 0xFC, 0x1C back-to-back.
  - Required: busy high for exactly 9 cycles starting the cycle after the last accept.
  - Required: out stream 0xFC, 0xFA, 0x1C, 0x1C; swap_count=3.
- Ascending input (worst case):
  - Load 0x00, 0x01, 0x02, 0x03.
  - Required: out 0x03, 0x02, 0x01, 0x00; swap_count=6.
- Pre-sorted and all-zero blocks:
  - Load 0xFF, 0x80, 0x01, 0x00. Required: same order out, swap_count=0.
  - Load 0x00 ×4. Required: four 0x00 out, swap_count=0.
- Handshake stalls:
  - Drop in_valid for 2 cycles mid-load. Required: no extra word is stored.
  - Drop out_ready for 3 cycles during OUT. Required: out_data and out_valid held, no word skipped or repeated.
  - Back-to-back blocks work with a correct second result.
- Reset mid-SORT:
  - Assert rst_n=0 during SORT cycle 4.
  - Required: immediate zero outputs.
  - Required: a fresh load of 0x05, 0x09, 0x01, 0x07 then outputs 0x09, 0x07, 0x05, 0x01 with swap_count=3.
